// File: rtl/spu32_cpu_mul_pkg.sv
// spu32_cpu_mul_pkg: shared RV32M multiply op encodings, equal to funct3[1:0]
package spu32_cpu_mul_pkg;
    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;
endpackage

// File: rtl/spu32_cpu_mul.sv
// spu32_cpu_mul: iterative radix-2^MUL_BITS shift-add multiplier for MUL/MULH/MULHSU/MULHU
module spu32_cpu_mul
    import spu32_cpu_mul_pkg::*;
#(
    parameter int MUL_BITS = 2
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_en,
    input  logic [31:0] I_op1,
    input  logic [31:0] I_op2,
    input  logic [1:0]  I_op,
    output logic [31:0] O_result,
    output logic        O_busy
);
    localparam int STEPS = 32 / MUL_BITS;
    localparam int CW = $clog2(STEPS + 1);

    if (MUL_BITS < 1 || MUL_BITS > 8 || 32 % MUL_BITS != 0) begin : g_bad_mul_bits
        $error("spu32_cpu_mul: MUL_BITS must be 1, 2, 4 or 8");
    end

    mul_op_t        op_q;
    logic           neg_res;
    logic [CW-1:0]  cnt;
    logic [63:0]    acc;
    logic [63:0]    mcand;
    logic [31:0]    mplier;
    logic           sign1;
    logic           sign2;
    logic [31:0]    mag1;
    logic [31:0]    mag2;
    logic [63:0]    prod;

    function automatic logic [63:0] partial(input logic [63:0] m, input logic [MUL_BITS-1:0] b);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < MUL_BITS; i++)
            s = s + (b[i] ? m << i : 64'd0);
        return s;
    endfunction

    // MUL takes the MULH sign rule; its low word is the same either way
    always_comb begin
        sign1 = I_op1[31] && I_op != MUL_OP_MULHU;
        sign2 = I_op2[31] && !I_op[1];
        mag1  = sign1 ? -I_op1 : I_op1;
        mag2  = sign2 ? -I_op2 : I_op2;
        prod  = neg_res ? -acc : acc;
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            O_busy   <= 1'b0;
            O_result <= '0;
        end else if (!O_busy) begin
            acc <= '0;
            if (I_en) begin
                op_q    <= mul_op_t'(I_op);
                neg_res <= sign1 ^ sign2;
                mcand   <= {32'b0, mag1};
                mplier  <= mag2;
                cnt     <= CW'(STEPS);
                O_busy  <= 1'b1;
            end
        end else if (cnt != '0) begin
            acc    <= acc + partial(mcand, mplier[MUL_BITS-1:0]);
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt - 1'b1;
        end else begin
            O_result <= op_q == MUL_OP_MUL ? prod[31:0] : prod[63:32];
            O_busy   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spu32_cpu_mul.sv
// tb_spu32_cpu_mul: checks four multiplier instances (MUL_BITS 1,2,4,8) against a signed-arithmetic model
module tb_spu32_cpu_mul;
    logic        I_clk = 1'b0;
    logic        I_reset = 1'b1;
    logic [3:0]  en = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [1:0]  op = '0;
    logic [31:0] res [4];
    logic [3:0]  busy;
    int          checks = 0;
    int          errors = 0;

    always #5 I_clk = ~I_clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spu32_cpu_mul #(.MUL_BITS(1 << g)) dut (
            .I_clk(I_clk),
            .I_reset(I_reset),
            .I_en(en[g]),
            .I_op1(op1),
            .I_op2(op2),
            .I_op(op),
            .O_result(res[g]),
            .O_busy(busy[g])
        );
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic [63:0] p;
        x = (o == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
        y = o[1] ? {32'b0, b} : {{32{b[31]}}, b};
        p = x * y;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // cycle model: an accepted start delivers its result 32/MUL_BITS+1 edges later
    logic [3:0]  mbusy = '0;
    logic [31:0] mres [4];
    logic [31:0] mpend [4];
    int          mleft [4];
    logic        mvalid = 1'b0;

    always @(posedge I_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (I_reset) begin
                mbusy[k] = 1'b0;
                mres[k] = '0;
            end else if (!mbusy[k]) begin
                if (en[k]) begin
                    mbusy[k] = 1'b1;
                    mleft[k] = 32 / (1 << k) + 1;
                    mpend[k] = ref_mul(op, op1, op2);
                end
            end else begin
                mleft[k]--;
                if (mleft[k] == 0) begin
                    mbusy[k] = 1'b0;
                    mres[k] = mpend[k];
                end
            end
        end
        if (I_reset) mvalid = 1'b1;
    end

    always @(negedge I_clk) begin
        if (mvalid) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (busy[k] !== mbusy[k] || res[k] !== mres[k]) begin
                    errors++;
                    $display("FAIL cycle dut%0d @%0t: busy=%b result=%h, expected busy=%b result=%h",
                             k, $time, busy[k], res[k], mbusy[k], mres[k]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run(input int k, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int blen);
        op = o;
        op1 = a;
        op2 = b;
        en[k] = 1'b1;
        @(negedge I_clk);
        en[k] = 1'b0;
        blen = 0;
        while (busy[k] && blen < 100) begin
            blen++;
            @(negedge I_clk);
        end
        if (blen >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: busy still %b after %0d cycles, expected 0", k, busy[k], blen);
        end
        r = res[k];
    endtask

    logic [1:0]  vo [8] = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1};
    logic [31:0] va [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [8] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] ve [8] = '{32'h0000_002A, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF,
                            32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFF};

    initial begin
        logic [31:0] r;
        int bl;
        int t;
        logic [1:0] o;
        logic [31:0] a;
        logic [31:0] b;
        int k;
        repeat (2) @(negedge I_clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_busy_dut%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset_result_dut%0d", i), res[i], 32'd0);
        end
        I_reset = 1'b0;
        for (int i = 0; i < 8; i++)
            check($sformatf("model_pin%0d", i), ref_mul(vo[i], va[i], vb[i]), ve[i]);
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 8; i++) begin
                run(d, vo[i], va[i], vb[i], r, bl);
                check($sformatf("lit%0d_dut%0d", i, d), r, ve[i]);
                check($sformatf("busy_len%0d_dut%0d", i, d), 32'(bl), 32'(32 / (1 << d) + 1));
            end
        end
        op = 2'd0;
        op1 = 32'd3;
        op2 = 32'd5;
        en[1] = 1'b1;
        @(negedge I_clk);
        t = 0;
        while (busy[1] && t < 100) begin
            op1 = $urandom;
            op2 = $urandom;
            op = 2'($urandom);
            en[1] = 1'b1;
            t++;
            @(negedge I_clk);
        end
        en[1] = 1'b0;
        check("ignore_en_result", res[1], 32'h0000_000F);
        check("ignore_en_len", 32'(t), 32'd17);
        op = 2'd1;
        op1 = 32'h1234_5678;
        op2 = 32'h9ABC_DEF0;
        en[1] = 1'b1;
        @(negedge I_clk);
        en[1] = 1'b0;
        repeat (4) @(negedge I_clk);
        I_reset = 1'b1;
        @(negedge I_clk);
        I_reset = 1'b0;
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_result", res[1], 32'd0);
        run(1, 2'd3, 32'h0001_0000, 32'h0001_0000, r, bl);
        check("after_abort_mulhu", r, 32'h0000_0001);
        repeat (800) begin
            op1 = rnd();
            op2 = rnd();
            op = 2'($urandom);
            en = 4'($urandom);
            I_reset = ($urandom_range(0, 99) == 0);
            @(negedge I_clk);
        end
        en = '0;
        I_reset = 1'b0;
        repeat (40) @(negedge I_clk);
        repeat (24) begin
            k = $urandom_range(0, 3);
            o = 2'($urandom);
            a = rnd();
            b = rnd();
            run(k, o, a, b, r, bl);
            check($sformatf("rand_dut%0d_op%0d_%h_%h", k, o, a, b), r, ref_mul(o, a, b));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
